// File: rtl/image_kernel_mc.sv
// image_kernel_mc: line-buffered KxK multi-channel window generator for the
// pixel stream. It keeps K-1 previous rows in a line buffer and emits a KxK
// window of packed pixels, with optional per-frame bypass, measured output
// dimensions and sticky row-length / overflow error flags.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 8'h01
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 8'h02
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 8'h04
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 8'h08
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 8'h10
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 8'h10
`endif

module image_kernel_mc #(
  parameter int KERNEL_SIZE    = 3,
  parameter int DATA_WIDTH     = 8,
  parameter int CHANNELS       = 1,
  parameter int MAX_COLS       = 1288,
  parameter int NUM_COLS_WIDTH = 11,
  parameter int NUM_ROWS_WIDTH = 10
) (
  input  logic                                                  clk,
  input  logic                                                  resetb,
  input  logic                                                  enable,
  input  logic                                                  dvi,
  input  logic [`DTYPE_WIDTH-1:0]                               dtypei,
  input  logic [DATA_WIDTH*CHANNELS-1:0]                        datai,
  output logic                                                  dvo,
  output logic [`DTYPE_WIDTH-1:0]                               dtypeo,
  output logic [KERNEL_SIZE*KERNEL_SIZE*CHANNELS*DATA_WIDTH-1:0] datao,
  output logic [NUM_COLS_WIDTH-1:0]                             out_cols,
  output logic [NUM_ROWS_WIDTH-1:0]                             out_rows,
  output logic                                                  err_row_len,
  output logic                                                  err_overflow
);

  localparam int K    = KERNEL_SIZE;
  localparam int B    = KERNEL_SIZE / 2;
  localparam int PW   = DATA_WIDTH * CHANNELS;
  localparam int LBW  = (K - 1) * PW;
  localparam int WINW = K * K * PW;
  localparam int LBAW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;

  localparam logic [NUM_COLS_WIDTH-1:0] C_EDGE = NUM_COLS_WIDTH'(2 * B);
  localparam logic [NUM_ROWS_WIDTH-1:0] R_EDGE = NUM_ROWS_WIDTH'(2 * B);
  localparam logic [NUM_COLS_WIDTH-1:0] C_MAX  = NUM_COLS_WIDTH'(MAX_COLS);
  localparam logic [NUM_COLS_WIDTH-1:0] C_ONE  = NUM_COLS_WIDTH'(1);
  localparam logic [NUM_ROWS_WIDTH-1:0] R_ONE  = NUM_ROWS_WIDTH'(1);

  // Frame / mode state. r_mode is 1 for kernel mode, 0 for bypass.
  logic                      r_active;
  logic                      r_mode;
  logic [NUM_ROWS_WIDTH-1:0] r_row;
  logic [NUM_COLS_WIDTH-1:0] r_col;
  logic [NUM_COLS_WIDTH-1:0] r_numCols;

  // Registered outputs.
  logic                      r_dvo;
  logic [`DTYPE_WIDTH-1:0]   r_dtypeo;
  logic [WINW-1:0]           r_win;
  logic [NUM_COLS_WIDTH-1:0] r_outCols;
  logic [NUM_ROWS_WIDTH-1:0] r_outRows;
  logic                      r_errRowLen;
  logic                      r_errOverflow;

  // Line buffer: each address holds one column of the K-1 previous rows,
  // row 0 (oldest) in the LSBs.
  logic [LBW-1:0] r_lineBuf [MAX_COLS];

  logic                      w_isPixel;
  logic                      w_isFrameStart;
  logic                      w_isFrameEnd;
  logic                      w_isRowStart;
  logic                      w_isRowEnd;
  logic                      w_inRange;
  logic                      w_rowOk;
  logic                      w_colOk;
  logic                      w_lbWrite;
  logic [LBAW-1:0]           w_lbAddr;
  logic [LBW-1:0]            w_lbRead;
  logic [WINW-1:0]           w_winShift;
  logic [WINW-1:0]           w_winBypass;
  logic [NUM_COLS_WIDTH-1:0] w_outCols;
  logic [NUM_ROWS_WIDTH-1:0] w_outRows;

  assign w_isPixel      = |(dtypei & `DTYPE_PIXEL_MASK);
  assign w_isFrameStart = (dtypei == `DTYPE_FRAME_START);
  assign w_isFrameEnd   = (dtypei == `DTYPE_FRAME_END);
  assign w_isRowStart   = (dtypei == `DTYPE_ROW_START);
  assign w_isRowEnd     = (dtypei == `DTYPE_ROW_END);

  assign w_inRange = (r_col < C_MAX);
  assign w_rowOk   = (r_row >= R_EDGE);
  assign w_colOk   = (r_col >= C_EDGE);

  assign w_lbAddr  = r_col[LBAW-1:0];
  assign w_lbRead  = r_lineBuf[w_lbAddr];
  assign w_lbWrite = resetb && dvi && w_isPixel && r_active && r_mode && w_inRange;

  assign w_outCols = (r_numCols > C_EDGE) ? (r_numCols - C_EDGE) : '0;
  assign w_outRows = (r_row > R_EDGE) ? (r_row - R_EDGE) : '0;

  // Next window contents: shift every tap row left and load a new right column.
  always_comb begin
    w_winShift  = r_win;
    w_winBypass = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        w_winShift[(r*K+c)*PW +: PW] = r_win[(r*K+c+1)*PW +: PW];
      end
      if (r < K - 1) begin
        w_winShift[(r*K+K-1)*PW +: PW] = w_lbRead[r*PW +: PW];
      end else begin
        w_winShift[(r*K+K-1)*PW +: PW] = datai;
      end
    end
    w_winBypass[(B*K+B)*PW +: PW] = datai;
  end

  // Line buffer update: shift the addressed column up one row and insert the new pixel.
  always_ff @(posedge clk) begin
    if (w_lbWrite) begin
      r_lineBuf[w_lbAddr] <= {datai, w_lbRead[LBW-1:PW]};
    end
  end

  // Decode each beat and update counters, flags, window and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_active      <= 1'b0;
      r_mode        <= 1'b1;
      r_row         <= '0;
      r_col         <= '0;
      r_numCols     <= '0;
      r_dvo         <= 1'b0;
      r_dtypeo      <= '0;
      r_win         <= '0;
      r_outCols     <= '0;
      r_outRows     <= '0;
      r_errRowLen   <= 1'b0;
      r_errOverflow <= 1'b0;
    end else begin
      r_dtypeo <= dtypei;
      r_dvo    <= 1'b0;
      if (dvi) begin
        if (w_isPixel) begin
          if (r_active) begin
            if (w_inRange) begin
              r_col <= r_col + C_ONE;
            end else begin
              r_errOverflow <= 1'b1;
            end
            if (!r_mode) begin
              r_win <= w_winBypass;
              r_dvo <= 1'b1;
            end else if (w_inRange) begin
              r_win <= w_winShift;
              r_dvo <= w_rowOk && w_colOk;
            end
          end
        end else if (w_isFrameStart) begin
          r_active      <= 1'b1;
          r_mode        <= enable;
          r_row         <= '0;
          r_col         <= '0;
          r_errRowLen   <= 1'b0;
          r_errOverflow <= 1'b0;
          r_dvo         <= 1'b1;
        end else if (r_active) begin
          if (w_isFrameEnd) begin
            r_dvo     <= 1'b1;
            r_outCols <= w_outCols;
            r_outRows <= w_outRows;
          end else if (w_isRowStart) begin
            r_col <= '0;
            r_dvo <= !r_mode || w_rowOk;
          end else if (w_isRowEnd) begin
            if (r_row == '0) begin
              r_numCols <= r_col;
            end else if (r_col != r_numCols) begin
              r_errRowLen <= 1'b1;
            end
            if (!(&r_row)) begin
              r_row <= r_row + R_ONE;
            end
            r_dvo <= !r_mode || w_rowOk;
          end else begin
            r_dvo <= 1'b1;
          end
        end
      end
    end
  end

  assign dvo          = r_dvo;
  assign dtypeo       = r_dtypeo;
  assign datao        = r_win;
  assign out_cols     = r_outCols;
  assign out_rows     = r_outRows;
  assign err_row_len  = r_errRowLen;
  assign err_overflow = r_errOverflow;

endmodule

// File: tb/tb_image_kernel_mc.sv
// tb_image_kernel_mc: scoreboard bench for image_kernel_mc. Instance A is the
// 3x3 single-channel build, instance B the 5x5 three-channel build with a
// 16-pixel line buffer.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 8'h01
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 8'h02
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 8'h04
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 8'h08
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 8'h10
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 8'h10
`endif

module tb_image_kernel_mc;

  localparam int KA = 3;
  localparam int KB = 5;
  localparam int WA = KA * KA * 8;
  localparam int WB = KB * KB * 3 * 8;

  localparam logic [7:0] T_FS   = `DTYPE_FRAME_START;
  localparam logic [7:0] T_FE   = `DTYPE_FRAME_END;
  localparam logic [7:0] T_RS   = `DTYPE_ROW_START;
  localparam logic [7:0] T_RE   = `DTYPE_ROW_END;
  localparam logic [7:0] T_PIX  = `DTYPE_PIXEL;
  localparam logic [7:0] T_META = 8'h40;

  typedef struct {
    logic [7:0]    t;
    logic [WB-1:0] d;
    bit            chk;
  } expT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          aResetb, aEnable, aDvi;
  logic [7:0]    aDtype, aData;
  logic          aDvo;
  logic [7:0]    aDtypeo;
  logic [WA-1:0] aDatao;
  logic [10:0]   aOutCols;
  logic [9:0]    aOutRows;
  logic          aErrRow, aErrOvf;

  logic          bResetb, bEnable, bDvi;
  logic [7:0]    bDtype;
  logic [23:0]   bData;
  logic          bDvo;
  logic [7:0]    bDtypeo;
  logic [WB-1:0] bDatao;
  logic [10:0]   bOutCols;
  logic [9:0]    bOutRows;
  logic          bErrRow, bErrOvf;

  int vectors = 0;
  int miscompares = 0;
  int aPix, aRs, aRe, bPix;
  logic [WA-1:0] aFirst, aLast;
  expT qA[$];
  expT qB[$];
  expT eA, eB;
  logic [23:0] imgB [0:9][0:17];

  image_kernel_mc #(
    .KERNEL_SIZE(3), .DATA_WIDTH(8), .CHANNELS(1), .MAX_COLS(1288),
    .NUM_COLS_WIDTH(11), .NUM_ROWS_WIDTH(10)
  ) dutA (
    .clk(clk), .resetb(aResetb), .enable(aEnable), .dvi(aDvi), .dtypei(aDtype),
    .datai(aData), .dvo(aDvo), .dtypeo(aDtypeo), .datao(aDatao), .out_cols(aOutCols),
    .out_rows(aOutRows), .err_row_len(aErrRow), .err_overflow(aErrOvf)
  );

  image_kernel_mc #(
    .KERNEL_SIZE(5), .DATA_WIDTH(8), .CHANNELS(3), .MAX_COLS(16),
    .NUM_COLS_WIDTH(11), .NUM_ROWS_WIDTH(10)
  ) dutB (
    .clk(clk), .resetb(bResetb), .enable(bEnable), .dvi(bDvi), .dtypei(bDtype),
    .datai(bData), .dvo(bDvo), .dtypeo(bDtypeo), .datao(bDatao), .out_cols(bOutCols),
    .out_rows(bOutRows), .err_row_len(bErrRow), .err_overflow(bErrOvf)
  );

  // Scoreboard for instance A: every valid output must match the oldest pending expectation.
  always @(negedge clk) begin
    if (aDvo === 1'b1) begin
      vectors++;
      if (qA.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL monA_unexpected got dtype=%h exp=no output", aDtypeo);
      end else begin
        eA = qA.pop_front();
        if (aDtypeo !== eA.t || (eA.chk && aDatao !== eA.d[WA-1:0])) begin
          miscompares++;
          $display("[TB] FAIL monA_beat got dtype=%h data=%h exp dtype=%h data=%h",
                   aDtypeo, aDatao, eA.t, eA.d[WA-1:0]);
        end
      end
      if (aDtypeo == T_PIX) begin
        if (aPix == 0) aFirst = aDatao;
        aLast = aDatao;
        aPix++;
      end
      if (aDtypeo == T_RS) aRs++;
      if (aDtypeo == T_RE) aRe++;
    end
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin
    if (bDvo === 1'b1) begin
      vectors++;
      if (qB.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL monB_unexpected got dtype=%h exp=no output", bDtypeo);
      end else begin
        eB = qB.pop_front();
        if (bDtypeo !== eB.t || (eB.chk && bDatao !== eB.d)) begin
          miscompares++;
          $display("[TB] FAIL monB_beat got dtype=%h data=%h exp dtype=%h data=%h",
                   bDtypeo, bDatao, eB.t, eB.d);
        end
      end
      if (bDtypeo == T_PIX) bPix++;
    end
  end

  function automatic logic [23:0] pix(input int sel, input int r, input int c);
    logic [7:0] v;
    if (sel == 0) begin
      v = 8'((r * 16 + c) & 255);
      return {16'h0000, v};
    end
    return imgB[r][c];
  endfunction

  // Window whose bottom-right tap is input pixel (r,c); row 0 oldest, col 0 leftmost.
  function automatic logic [WB-1:0] expWin(input int sel, input int r, input int c);
    logic [WB-1:0] w;
    logic [23:0]   p;
    int            k;
    w = '0;
    k = (sel == 0) ? KA : KB;
    for (int i = 0; i < k; i++) begin
      for (int j = 0; j < k; j++) begin
        p = pix(sel, r - (k - 1) + i, c - (k - 1) + j);
        if (sel == 0) w[(i*k+j)*8 +: 8] = p[7:0];
        else w[(i*k+j)*24 +: 24] = p;
      end
    end
    return w;
  endfunction

  task automatic pushExp(input int sel, input logic [7:0] t, input logic [WB-1:0] d, input bit chk);
    expT e;
    e.t = t;
    e.d = d;
    e.chk = chk;
    if (sel == 0) qA.push_back(e);
    else qB.push_back(e);
  endtask

  task automatic beat(input int sel, input logic v, input logic [7:0] t, input logic [23:0] d);
    aDvi = 1'b0; aDtype = 8'h00; aData = 8'h00;
    bDvi = 1'b0; bDtype = 8'h00; bData = 24'h0;
    if (sel == 0) begin
      aDvi = v; aDtype = t; aData = d[7:0];
    end else begin
      bDvi = v; bDtype = t; bData = d;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic gapBeats(input int sel, input int idlePct);
    for (int g = 0; g < 3; g++) begin
      if ($urandom_range(99) < idlePct) beat(sel, 1'b0, 8'h00, 24'h0);
    end
  endtask

  task automatic setEnable(input int sel, input logic v);
    if (sel == 0) aEnable = v;
    else bEnable = v;
  endtask

  // Drive rows [r0,r1) of a frame and push the outputs the block should produce.
  task automatic applyStimulus(input int sel, input int r0, input int r1, input int cols,
                               input bit kern, input int shortRow, input int overRow,
                               input int toggleRow, input int idlePct,
                               input bit doStart, input bit doEnd);
    int twoB, maxc, len, pos;
    logic [WB-1:0] cen;
    twoB = (sel == 0) ? 2 : 4;
    maxc = (sel == 0) ? 1288 : 16;
    pos  = (sel == 0) ? 32 : 288;
    if (doStart) begin
      setEnable(sel, kern);
      gapBeats(sel, idlePct);
      pushExp(sel, T_FS, '0, 1'b0);
      beat(sel, 1'b1, T_FS, 24'h0);
    end
    for (int r = r0; r < r1; r++) begin
      if (r == toggleRow) setEnable(sel, !kern);
      len = cols - ((r == shortRow) ? 2 : 0) + ((r == overRow) ? 2 : 0);
      gapBeats(sel, idlePct);
      if (!kern || r >= twoB) pushExp(sel, T_RS, '0, 1'b0);
      beat(sel, 1'b1, T_RS, 24'h0);
      for (int c = 0; c < len; c++) begin
        gapBeats(sel, idlePct);
        if (!kern) begin
          cen = '0;
          cen[pos +: 24] = pix(sel, r, c);
          pushExp(sel, T_PIX, cen, 1'b1);
        end else if (r >= twoB && c >= twoB && c < maxc) begin
          pushExp(sel, T_PIX, expWin(sel, r, c), 1'b1);
        end
        beat(sel, 1'b1, T_PIX, pix(sel, r, c));
      end
      gapBeats(sel, idlePct);
      if (!kern || r >= twoB) pushExp(sel, T_RE, '0, 1'b0);
      beat(sel, 1'b1, T_RE, 24'h0);
    end
    if (doEnd) begin
      gapBeats(sel, idlePct);
      pushExp(sel, T_FE, '0, 1'b0);
      beat(sel, 1'b1, T_FE, 24'h0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) beat(0, 1'b0, 8'h00, 24'h0);
  endtask

  task automatic test_reset();
    aResetb = 1'b0;
    bResetb = 1'b0;
    beat(0, 1'b1, T_PIX, 24'h0000AA);
    beat(1, 1'b1, T_PIX, 24'h123456);
    vectors++; if (aDvo !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_dvoA got=%b exp=0", aDvo); end
    vectors++; if (aDtypeo !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_dtypeoA got=%h exp=00", aDtypeo); end
    vectors++; if (aDatao !== '0) begin miscompares++; $display("[TB] FAIL reset_dataoA got=%h exp=0", aDatao); end
    vectors++; if (aOutCols !== 11'd0 || aOutRows !== 10'd0) begin miscompares++; $display("[TB] FAIL reset_dimsA got=%0d,%0d exp=0,0", aOutCols, aOutRows); end
    vectors++; if (aErrRow !== 1'b0 || aErrOvf !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_errA got=%b%b exp=00", aErrRow, aErrOvf); end
    vectors++; if (bDvo !== 1'b0 || bDatao !== '0) begin miscompares++; $display("[TB] FAIL reset_B got dvo=%b exp=0", bDvo); end
    aResetb = 1'b1;
    bResetb = 1'b1;
    drain();
  endtask

  task automatic test_ramp();
    aPix = 0; aRs = 0; aRe = 0;
    applyStimulus(0, 0, 6, 8, 1'b1, -1, -1, -1, 0, 1'b1, 1'b1);
    vectors++; if (aOutCols !== 11'd6 || aOutRows !== 10'd4) begin miscompares++; $display("[TB] FAIL ramp_dims got=%0dx%0d exp=6x4", aOutCols, aOutRows); end
    pushExp(0, T_META, '0, 1'b0);
    beat(0, 1'b1, T_META, 24'h0);
    beat(0, 1'b0, 8'h5A, 24'h0);
    vectors++; if (aDtypeo !== 8'h5A || aDvo !== 1'b0) begin miscompares++; $display("[TB] FAIL ramp_idle got dtype=%h dvo=%b exp dtype=5a dvo=0", aDtypeo, aDvo); end
    drain();
    vectors++; if (aPix != 24 || aRs != 4 || aRe != 4) begin miscompares++; $display("[TB] FAIL ramp_counts got=%0d/%0d/%0d exp=24/4/4", aPix, aRs, aRe); end
    vectors++; if (aFirst !== 72'h222120121110020100) begin miscompares++; $display("[TB] FAIL ramp_first got=%h exp=222120121110020100", aFirst); end
    vectors++; if (aLast[39:32] !== 8'h46) begin miscompares++; $display("[TB] FAIL ramp_last_centre got=%h exp=46", aLast[39:32]); end
    vectors++; if (aErrRow !== 1'b0 || aErrOvf !== 1'b0) begin miscompares++; $display("[TB] FAIL ramp_err got=%b%b exp=00", aErrRow, aErrOvf); end
  endtask

  task automatic test_k5_multichannel();
    bPix = 0;
    applyStimulus(1, 0, 10, 10, 1'b1, -1, -1, -1, 0, 1'b1, 1'b1);
    drain();
    vectors++; if (bPix != 36) begin miscompares++; $display("[TB] FAIL k5_count got=%0d exp=36", bPix); end
    vectors++; if (bOutCols !== 11'd6 || bOutRows !== 10'd6) begin miscompares++; $display("[TB] FAIL k5_dims got=%0dx%0d exp=6x6", bOutCols, bOutRows); end
  endtask

  task automatic test_overflow();
    bPix = 0;
    applyStimulus(1, 0, 5, 16, 1'b1, -1, 4, -1, 0, 1'b1, 1'b1);
    drain();
    vectors++; if (bErrOvf !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_flag got=%b exp=1", bErrOvf); end
    vectors++; if (bErrRow !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_rowlen got=%b exp=0", bErrRow); end
    vectors++; if (bPix != 12) begin miscompares++; $display("[TB] FAIL ovf_count got=%0d exp=12", bPix); end
    vectors++; if (bOutCols !== 11'd12 || bOutRows !== 10'd1) begin miscompares++; $display("[TB] FAIL ovf_dims got=%0dx%0d exp=12x1", bOutCols, bOutRows); end
  endtask

  task automatic test_bypass();
    aPix = 0;
    applyStimulus(0, 0, 6, 8, 1'b0, -1, -1, 2, 0, 1'b1, 1'b1);
    drain();
    vectors++; if (aPix != 48) begin miscompares++; $display("[TB] FAIL bypass_count got=%0d exp=48", aPix); end
    vectors++; if (aOutCols !== 11'd6 || aOutRows !== 10'd4) begin miscompares++; $display("[TB] FAIL bypass_dims got=%0dx%0d exp=6x4", aOutCols, aOutRows); end
    aPix = 0;
    applyStimulus(0, 0, 6, 8, 1'b1, -1, -1, -1, 0, 1'b1, 1'b1);
    drain();
    vectors++; if (aPix != 24) begin miscompares++; $display("[TB] FAIL bypass_next_kernel got=%0d exp=24", aPix); end
  endtask

  task automatic test_short_row();
    applyStimulus(0, 0, 4, 8, 1'b0, 3, -1, -1, 0, 1'b1, 1'b0);
    vectors++; if (aErrRow !== 1'b1) begin miscompares++; $display("[TB] FAIL short_set got=%b exp=1", aErrRow); end
    applyStimulus(0, 4, 6, 8, 1'b0, -1, -1, -1, 0, 1'b0, 1'b1);
    vectors++; if (aErrRow !== 1'b1) begin miscompares++; $display("[TB] FAIL short_sticky got=%b exp=1", aErrRow); end
    applyStimulus(0, 0, 0, 8, 1'b1, -1, -1, -1, 0, 1'b1, 1'b0);
    vectors++; if (aErrRow !== 1'b0) begin miscompares++; $display("[TB] FAIL short_clear got=%b exp=0", aErrRow); end
    drain();
  endtask

  task automatic test_back_to_back();
    applyStimulus(0, 0, 4, 8, 1'b1, -1, -1, -1, 0, 1'b1, 1'b0);
    drain();
    aResetb = 1'b0;
    beat(0, 1'b1, T_PIX, 24'h0000EE);
    aResetb = 1'b1;
    vectors++; if (aDvo !== 1'b0 || aDatao !== '0) begin miscompares++; $display("[TB] FAIL midreset_out got dvo=%b data=%h exp dvo=0 data=0", aDvo, aDatao); end
    vectors++; if (aOutCols !== 11'd0) begin miscompares++; $display("[TB] FAIL midreset_dims got=%0d exp=0", aOutCols); end
    for (int r = 4; r < 6; r++) begin
      beat(0, 1'b1, T_RS, 24'h0);
      for (int c = 0; c < 8; c++) beat(0, 1'b1, T_PIX, pix(0, r, c));
      beat(0, 1'b1, T_RE, 24'h0);
    end
    beat(0, 1'b1, T_FE, 24'h0);
    drain();
    vectors++; if (aOutCols !== 11'd0 || aOutRows !== 10'd0) begin miscompares++; $display("[TB] FAIL midreset_stale got=%0dx%0d exp=0x0", aOutCols, aOutRows); end
    aPix = 0;
    applyStimulus(0, 0, 6, 8, 1'b1, -1, -1, -1, 30, 1'b1, 1'b1);
    drain();
    vectors++; if (aPix != 24) begin miscompares++; $display("[TB] FAIL gaps_count got=%0d exp=24", aPix); end
    vectors++; if (aOutCols !== 11'd6 || aOutRows !== 10'd4) begin miscompares++; $display("[TB] FAIL gaps_dims got=%0dx%0d exp=6x4", aOutCols, aOutRows); end
    vectors++; if (qA.size() != 0 || qB.size() != 0) begin miscompares++; $display("[TB] FAIL pending got=%0d/%0d exp=0/0", qA.size(), qB.size()); end
  endtask

  initial begin
    aResetb = 1'b0; aEnable = 1'b1; aDvi = 1'b0; aDtype = 8'h00; aData = 8'h00;
    bResetb = 1'b0; bEnable = 1'b1; bDvi = 1'b0; bDtype = 8'h00; bData = 24'h0;
    aPix = 0; aRs = 0; aRe = 0; bPix = 0;
    aFirst = '0; aLast = '0;
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 18; c++) imgB[r][c] = 24'($urandom);
    end
    test_reset();
    test_ramp();
    test_k5_multichannel();
    test_overflow();
    test_bypass();
    test_short_row();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
